// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / memory-wait controller.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W = 3;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_ALU = 2'b01;
    localparam logic [1:0] FWD_RAM = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// Execute-stage operand forwarding select for one operand, taken from the Writeback-side register.
module fwd_sel_unit
#(
    parameter int ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
)
(
    input  logic [ADDR_W-1:0] ex_addr_i,
    input  logic              wb_wb_en_i,
    input  logic              wb_mem_re_i,
    input  logic [ADDR_W-1:0] wb_dest_addr_i,
    output logic [1:0]        sel_o
);
    import pipe_ctrl_pkg::*;

    always_comb begin
        sel_o = FWD_REG;
        if (wb_wb_en_i && (wb_dest_addr_i == ex_addr_i)) begin
            sel_o = wb_mem_re_i ? FWD_RAM : FWD_ALU;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use bubble insertion, RAM-wait freeze with timeout fault, forwarding selects and stall counter.
// All control outputs are combinational from current inputs and state; only state/counters are registered.
module pipe_hazard_ctrl
#(
    parameter int REG_ADDR_W  = pipe_ctrl_pkg::REG_ADDR_W,
    parameter int MEM_TIMEOUT = 8,
    parameter int STAT_W      = 8
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs_addr,
    input  logic [REG_ADDR_W-1:0] ex_rt_addr,
    input  logic                  ex_mem_re,
    input  logic                  ex_mem_we,
    input  logic                  ex_wb_en,
    input  logic [REG_ADDR_W-1:0] ex_dest_addr,
    input  logic                  wb_wb_en,
    input  logic                  wb_mem_re,
    input  logic [REG_ADDR_W-1:0] wb_dest_addr,
    input  logic                  ram_ready,
    input  logic                  stat_clr,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  idex_bubble,
    output logic                  stall,
    output logic                  ram_req,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  fault,
    output logic [STAT_W-1:0]     stall_count
);
    import pipe_ctrl_pkg::*;

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic mem_acc, req, freeze, rs_hit, rt_hit, lu, adv, wb_en_live;

    assign mem_acc = ex_mem_re | ex_mem_we;
    assign req     = ((state_q == RUN) && mem_acc) || (state_q == MEM_WAIT);
    assign freeze  = (req && !ram_ready) || (state_q == FAULT);

    assign rs_hit = id_uses_rs && (id_rs_addr == ex_dest_addr);
    assign rt_hit = id_uses_rt && (id_rt_addr == ex_dest_addr);
    // A load that is itself still waiting on RAM freezes instead of bubbling.
    assign lu     = (state_q == RUN) && (!mem_acc || ram_ready)
                 && ex_mem_re && ex_wb_en && (rs_hit || rt_hit);
    assign adv    = !(freeze || lu);

    assign pc_en       = !reset && adv;
    assign ifid_en     = !reset && adv;
    assign idex_en     = !reset && !freeze;
    assign idex_bubble = !reset && lu && !freeze;
    assign stall       = !reset && freeze;
    assign ram_req     = !reset && req;
    assign fault       = !reset && (state_q == FAULT);
    assign stall_count = stall_cnt_q;

    assign wb_en_live = wb_wb_en && !reset;

    fwd_sel_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_a (
        .ex_addr_i      (ex_rs_addr),
        .wb_wb_en_i     (wb_en_live),
        .wb_mem_re_i    (wb_mem_re),
        .wb_dest_addr_i (wb_dest_addr),
        .sel_o          (fwd_a_sel)
    );

    fwd_sel_unit #(.ADDR_W(REG_ADDR_W)) u_fwd_b (
        .ex_addr_i      (ex_rt_addr),
        .wb_wb_en_i     (wb_en_live),
        .wb_mem_re_i    (wb_mem_re),
        .wb_dest_addr_i (wb_dest_addr),
        .sel_o          (fwd_b_sel)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            RUN: begin
                if (mem_acc && !ram_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (ram_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: state_d = FAULT;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stat_clr) begin
            stall_cnt_d = '0;
        end else if (!adv && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario tasks plus randomized traffic, checked against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 8;
    localparam int STAT_W      = 8;
    localparam int STAT_MAX    = (1 << STAT_W) - 1;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_dest_addr, wb_dest_addr;
    logic       id_uses_rs, id_uses_rt, ex_mem_re, ex_mem_we, ex_wb_en;
    logic       wb_wb_en, wb_mem_re, ram_ready, stat_clr;
    logic       pc_en, ifid_en, idex_en, idex_bubble, stall, ram_req, fault;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic [STAT_W-1:0] stall_count;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_ADDR_W(3), .MEM_TIMEOUT(MEM_TIMEOUT), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_wb_en(ex_wb_en),
        .ex_dest_addr(ex_dest_addr),
        .wb_wb_en(wb_wb_en), .wb_mem_re(wb_mem_re), .wb_dest_addr(wb_dest_addr),
        .ram_ready(ram_ready), .stat_clr(stat_clr),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .idex_bubble(idex_bubble),
        .stall(stall), .ram_req(ram_req),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fault(fault), .stall_count(stall_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: length of the current unacknowledged access run, fault flag, stall counter.
    int m_pending;
    bit m_fault;
    int m_cnt;

    function automatic logic [1:0] fwd_exp(input logic [2:0] a);
        if (wb_wb_en && wb_dest_addr == a) return wb_mem_re ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // {pc_en, ifid_en, idex_en, idex_bubble, stall, ram_req, fault, fwd_a, fwd_b}
    function automatic logic [10:0] model_out();
        bit acc, req, frz, hit, lu, go;
        acc = ex_mem_re || ex_mem_we;
        req = !m_fault && (acc || m_pending > 0);
        frz = m_fault || (req && !ram_ready);
        hit = (id_uses_rs && id_rs_addr == ex_dest_addr) || (id_uses_rt && id_rt_addr == ex_dest_addr);
        lu  = !m_fault && m_pending == 0 && (!acc || ram_ready) && ex_mem_re && ex_wb_en && hit;
        go  = !(frz || lu);
        if (reset) return '0;
        return {go, go, !frz, lu && !frz, frz, req, m_fault, fwd_exp(ex_rs_addr), fwd_exp(ex_rt_addr)};
    endfunction

    function automatic logic [10:0] act();
        return {pc_en, ifid_en, idex_en, idex_bubble, stall, ram_req, fault, fwd_a_sel, fwd_b_sel};
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_fault   = 0;
        m_cnt     = 0;
    endtask

    task automatic model_tick();
        logic [10:0] e;
        e = model_out();
        if (!m_fault && (ex_mem_re || ex_mem_we || m_pending > 0)) begin
            if (ram_ready) m_pending = 0;
            else begin
                m_pending++;
                if (m_pending >= MEM_TIMEOUT) m_fault = 1;
            end
        end
        if (stat_clr) m_cnt = 0;
        else if (!e[10] && m_cnt < STAT_MAX) m_cnt++;
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) model_tick();
        #1;
    endtask

    task automatic clear_inputs();
        {id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_dest_addr, wb_dest_addr} = '0;
        {id_uses_rs, id_uses_rt, ex_mem_re, ex_mem_we, ex_wb_en} = '0;
        {wb_wb_en, wb_mem_re, stat_clr} = '0;
        ram_ready = 1'b1;
    endtask

    task automatic rand_inputs();
        id_rs_addr   = 3'($urandom_range(0, 3));
        id_rt_addr   = 3'($urandom_range(0, 3));
        ex_rs_addr   = 3'($urandom_range(0, 3));
        ex_rt_addr   = 3'($urandom_range(0, 3));
        ex_dest_addr = 3'($urandom_range(0, 3));
        wb_dest_addr = 3'($urandom_range(0, 3));
        id_uses_rs   = 1'($urandom);
        id_uses_rt   = 1'($urandom);
        ex_mem_re    = ($urandom_range(0, 9) < 3);
        ex_mem_we    = ($urandom_range(0, 9) < 2);
        ex_wb_en     = 1'($urandom);
        wb_wb_en     = 1'($urandom);
        wb_mem_re    = 1'($urandom);
        ram_ready    = ($urandom_range(0, 9) < 6);
        stat_clr     = ($urandom_range(0, 49) == 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            rand_inputs();
            #2;
            n_checks++;
            if (act() !== 11'b0) $display("FAIL reset_outputs: got %b expected %b", act(), 11'b0);
            else n_pass++;
            n_checks++;
            if (stall_count !== '0) $display("FAIL reset_count: got %0d expected 0", stall_count);
            else n_pass++;
        end
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_forwarding();
        do_reset();
        wb_wb_en = 1; wb_dest_addr = 5; wb_mem_re = 0; ex_rs_addr = 5; ex_rt_addr = 2;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) $display("FAIL fwd_alu: got %b expected 0100", {fwd_a_sel, fwd_b_sel});
        else n_pass++;
        wb_wb_en = 0;
        #1;
        n_checks++;
        if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) $display("FAIL fwd_off: got %b expected 0000", {fwd_a_sel, fwd_b_sel});
        else n_pass++;
        for (int i = 0; i < 40; i++) begin
            rand_inputs();
            #1;
            n_checks++;
            if ({fwd_a_sel, fwd_b_sel} !== {fwd_exp(ex_rs_addr), fwd_exp(ex_rt_addr)})
                $display("FAIL fwd_rand: got %b expected %b", {fwd_a_sel, fwd_b_sel},
                         {fwd_exp(ex_rs_addr), fwd_exp(ex_rt_addr)});
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_re = 1; ex_wb_en = 1; ex_dest_addr = 3; id_rs_addr = 3; id_uses_rs = 1; ram_ready = 1;
        @(negedge clk);
        n_checks++;
        if ({pc_en, ifid_en, idex_bubble, idex_en} !== 4'b0011)
            $display("FAIL lu_bubble: got %b expected 0011", {pc_en, ifid_en, idex_bubble, idex_en});
        else n_pass++;
        advance();
        ex_mem_re = 0; ex_wb_en = 0; ex_rs_addr = 3;
        wb_wb_en = 1; wb_dest_addr = 3; wb_mem_re = 1;
        @(negedge clk);
        n_checks++;
        if ({fwd_a_sel, pc_en, idex_bubble} !== 4'b1010)
            $display("FAIL lu_after: got %b expected 1010", {fwd_a_sel, pc_en, idex_bubble});
        else n_pass++;
        advance();
    endtask

    task automatic test_mem_wait();
        do_reset();
        ex_mem_we = 1;
        for (int i = 0; i < 4; i++) begin
            ram_ready = (i == 3);
            @(negedge clk);
            n_checks++;
            if ({ram_req, stall, pc_en, ifid_en, idex_en} !== ((i == 3) ? 5'b10111 : 5'b11000))
                $display("FAIL memwait_c%0d: got %b expected %b", i, {ram_req, stall, pc_en, ifid_en, idex_en},
                         (i == 3) ? 5'b10111 : 5'b11000);
            else n_pass++;
            n_checks++;
            if (act() !== model_out()) $display("FAIL memwait_model: got %b expected %b", act(), model_out());
            else n_pass++;
            advance();
        end
        ex_mem_we = 0;
        @(negedge clk);
        n_checks++;
        if ({ram_req, stall, stall_count} !== {2'b00, 8'd3})
            $display("FAIL memwait_end: got %b expected %b", {ram_req, stall, stall_count}, {2'b00, 8'd3});
        else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        ex_mem_re = 1; ex_wb_en = 1; ex_dest_addr = 4; id_rt_addr = 4; id_uses_rt = 1;
        for (int i = 0; i < 3; i++) begin
            ram_ready = (i == 2);
            @(negedge clk);
            if (i < 2) begin
                n_checks++;
                if ({idex_bubble, idex_en, stall} !== 3'b001)
                    $display("FAIL prio_frozen: got %b expected 001", {idex_bubble, idex_en, stall});
                else n_pass++;
            end
            n_checks++;
            if (act() !== model_out()) $display("FAIL prio_model: got %b expected %b", act(), model_out());
            else n_pass++;
            advance();
        end
    endtask

    task automatic test_timeout();
        do_reset();
        ex_mem_re = 1; ram_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            @(negedge clk);
            n_checks++;
            if (act() !== model_out()) $display("FAIL timeout_run: got %b expected %b", act(), model_out());
            else n_pass++;
            advance();
        end
        @(negedge clk);
        n_checks++;
        if ({fault, ram_req, stall} !== 3'b101)
            $display("FAIL timeout_fault: got %b expected 101", {fault, ram_req, stall});
        else n_pass++;
        ram_ready = 1;
        for (int i = 0; i < 3; i++) advance();
        @(negedge clk);
        n_checks++;
        if ({fault, ram_req, pc_en, idex_en} !== 4'b1000)
            $display("FAIL fault_sticky: got %b expected 1000", {fault, ram_req, pc_en, idex_en});
        else n_pass++;
        do_reset();
        @(negedge clk);
        n_checks++;
        if ({fault, pc_en} !== 2'b01) $display("FAIL fault_clear: got %b expected 01", {fault, pc_en});
        else n_pass++;
    endtask

    task automatic test_counter();
        do_reset();
        ex_mem_we = 1; ram_ready = 0;
        for (int i = 0; i < 300; i++) advance();
        n_checks++;
        if (stall_count !== 8'd255) $display("FAIL cnt_sat: got %0d expected 255", stall_count);
        else n_pass++;
        stat_clr = 1;
        advance();
        stat_clr = 0;
        n_checks++;
        if (stall_count !== 8'd0) $display("FAIL cnt_clr: got %0d expected 0", stall_count);
        else n_pass++;
        do_reset();
        ex_mem_we = 1; ram_ready = 0;
        advance();
        advance();
        ex_mem_we = 0;
        n_checks++;
        if (ram_req !== 1'b1) $display("FAIL wait_req: got %b expected 1", ram_req);
        else n_pass++;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({ram_req, stall, fault} !== 3'b000) $display("FAIL async_rst: got %b expected 000", {ram_req, stall, fault});
        else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ram_req, pc_en} !== 2'b01) $display("FAIL rst_run: got %b expected 01", {ram_req, pc_en});
        else n_pass++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rand_inputs();
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                model_reset();
            end else begin
                reset = 1'b0;
            end
            @(negedge clk);
            n_checks++;
            if (act() !== model_out()) $display("FAIL rand_out @%0d: got %b expected %b", i, act(), model_out());
            else n_pass++;
            n_checks++;
            if (stall_count !== STAT_W'(m_cnt)) $display("FAIL rand_cnt @%0d: got %0d expected %0d", i, stall_count, m_cnt);
            else n_pass++;
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        reset = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_priority();
        test_timeout();
        test_counter();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
